// File: rtl/convolution_core_pkg.sv
// convolution_core_pkg: derived constants and the saturate/offset helper for the FIR core
package convolution_core_pkg;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_W      = 16;
    localparam int TAP_ADDR_W = $clog2(DEF_DEPTH);
    localparam int ACC_W      = 2 * DEF_W + TAP_ADDR_W;
    localparam int OFFSET     = 2 ** (DEF_W - 1);

    function automatic int tap_addr_w(input int d);
        return $clog2(d);
    endfunction

    function automatic int acc_w(input int w, input int d);
        return 2 * w + $clog2(d);
    endfunction

    // Clamp a signed value to the signed w-bit range, then convert to offset-binary
    function automatic logic [31:0] sat_offset(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        return 32'(((v > hi) ? hi : (v < -hi - 1) ? -hi - 1 : v) + hi + 1);
    endfunction
endpackage

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: pipelined binary adder tree, one register stage per tree level
module conv_adder_tree #(
    parameter int N     = 16,
    parameter int IN_W  = 32,
    parameter int OUT_W = IN_W + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [IN_W-1:0]  i_data [N],
    output logic signed [OUT_W-1:0] o_sum
);
    logic signed [OUT_W-1:0] r_node [1:N-1];
    logic signed [OUT_W-1:0] w_node [1:2*N-1];

    genvar n;
    for (n = 1; n < 2 * N; n++) begin : g_node
        if (n < N) begin : g_int
            assign w_node[n] = r_node[n];
        end else begin : g_leaf
            assign w_node[n] = OUT_W'(i_data[n-N]);
        end
    end

    // Heap-ordered nodes: node k sums children 2k and 2k+1, so each level adds one register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 1; k < N; k++) r_node[k] <= '0;
        end else begin
            for (int k = 1; k < N; k++) r_node[k] <= w_node[2*k] + w_node[2*k+1];
        end
    end

    assign o_sum = w_node[1];
endmodule

// File: rtl/convolution_core.sv
// convolution_core: pipelined FIR filter with bus-programmable coefficients
module convolution_core
    import convolution_core_pkg::*;
#(
    parameter int CONV_CORE_DEPTH   = 16,
    parameter int DATA_BITWIDTH     = 16,
    parameter int OUTPUT_SHIFT_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     data_in_enable,
    input  logic [DATA_BITWIDTH-1:0] data_in,
    output logic                     data_pp_out_enable,
    output logic [DATA_BITWIDTH-1:0] data_pp_out,
    output logic [DATA_BITWIDTH-1:0] data_res_out,
    input  logic                     p_sel,
    input  logic                     p_ce,
    input  logic                     p_we,
    input  logic [3:0]               p_strb,
    input  logic [31:0]              p_addr,
    input  logic [31:0]              p_wdata,
    output logic                     p_rdy,
    output logic [31:0]              p_rdata
);
    localparam int D  = CONV_CORE_DEPTH;
    localparam int W  = DATA_BITWIDTH;
    localparam int TW = tap_addr_w(D);
    localparam int AW = acc_w(W, D);
    localparam int L  = TW + 2;

    logic [31:0]         r_coef    [D];
    logic signed [W-1:0] r_x       [D];
    logic signed [2*W-1:0] r_prod  [D];
    logic [W-1:0]        r_pp_data [L+1];
    logic [L:0]          r_pp_en;
    logic [W-1:0]        r_res;
    logic signed [AW-1:0] w_sum;
    logic                w_hit;
    logic                w_wr;
    logic [TW-1:0]       w_idx;

    assign w_hit = p_addr < 32'(D);
    assign w_wr  = p_sel & p_ce & p_we & w_hit;
    assign w_idx = p_addr[TW-1:0];
    assign p_rdy = p_sel & p_ce;
    assign p_rdata = (p_sel & ~p_we & w_hit) ? r_coef[w_idx] : '0;

    // Coefficient registers with per-byte-lane writes
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 0; k < D; k++) r_coef[k] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < 4; b++) if (p_strb[b]) r_coef[w_idx][8*b +: 8] <= p_wdata[8*b +: 8];
        end
    end

    // Sample delay line; flipping the MSB converts offset-binary to two's complement
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 0; k < D; k++) r_x[k] <= '0;
        end else if (data_in_enable) begin
            r_x[0] <= $signed({~data_in[W-1], data_in[W-2:0]});
            for (int k = 1; k < D; k++) r_x[k] <= r_x[k-1];
        end
    end

    // Product stage runs every cycle so coefficient writes apply to the next products
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 0; k < D; k++) r_prod[k] <= '0;
        end else begin
            for (int k = 0; k < D; k++) r_prod[k] <= $signed(r_coef[k][W-1:0]) * r_x[k];
        end
    end

    conv_adder_tree #(.N(D), .IN_W(2 * W), .OUT_W(AW)) u_tree (
        .clk    (clk),
        .rstn   (rstn),
        .i_data (r_prod),
        .o_sum  (w_sum)
    );

    // Output stage: shift, saturate, and return to offset-binary
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) r_res <= '0;
        else      r_res <= W'(sat_offset(longint'(w_sum >>> OUTPUT_SHIFT_BITS), W));
    end

    // Raw sample and enable tag ride alongside the arithmetic to stay time-aligned
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_pp_en <= '0;
            for (int k = 0; k <= L; k++) r_pp_data[k] <= '0;
        end else begin
            r_pp_en      <= {r_pp_en[L-1:0], data_in_enable};
            r_pp_data[0] <= data_in;
            for (int k = 1; k <= L; k++) r_pp_data[k] <= r_pp_data[k-1];
        end
    end

    assign data_pp_out_enable = r_pp_en[L];
    assign data_pp_out        = r_pp_data[L];
    assign data_res_out       = r_res;
endmodule

// File: tb/tb_convolution_core.sv
// tb_convolution_core: scoreboard bench for the FIR core and its coefficient bus
module tb_convolution_core;
    localparam int D = 16;
    localparam int L = 6;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] pp;
        logic        en;
    } exp_t;

    logic        clk = 0;
    logic        rstn = 1;
    logic        en = 0;
    logic [15:0] din = 16'h8000;
    logic        p_sel = 0, p_ce = 0, p_we = 0;
    logic [3:0]  p_strb = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;
    logic        pp_en, p_rdy;
    logic [15:0] pp_out, res_out;
    logic [31:0] p_rdata;

    exp_t        q[$];
    logic [31:0] m_c [D];
    int          m_x [D];
    int          n_checks = 0;
    int          n_fail = 0;

    convolution_core dut (
        .clk                (clk),
        .rstn               (rstn),
        .data_in_enable     (en),
        .data_in            (din),
        .data_pp_out_enable (pp_en),
        .data_pp_out        (pp_out),
        .data_res_out       (res_out),
        .p_sel              (p_sel),
        .p_ce               (p_ce),
        .p_we               (p_we),
        .p_strb             (p_strb),
        .p_addr             (p_addr),
        .p_wdata            (p_wdata),
        .p_rdy              (p_rdy),
        .p_rdata            (p_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_res();
        longint acc = 0;
        for (int k = 0; k < D; k++) acc += longint'($signed(m_c[k][15:0])) * m_x[k];
        acc = acc >>> 12;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc + 32768);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            m_c[k] = 0;
            m_x[k] = 0;
        end
        q.delete();
    endtask

    task automatic step();
        exp_t e, g;
        @(posedge clk);
        #1;
        if (p_sel && p_ce && p_we && p_addr < D)
            for (int b = 0; b < 4; b++) if (p_strb[b]) m_c[p_addr][8*b +: 8] = p_wdata[8*b +: 8];
        if (en) begin
            for (int k = D - 1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = int'(din) - 32768;
        end
        e.res = model_res();
        e.pp = din;
        e.en = en;
        q.push_back(e);
        if (q.size() > L) begin
            g = q.pop_front();
            n_checks++;
            if ({res_out, pp_out, pp_en} !== {g.res, g.pp, g.en}) begin
                n_fail++;
                $display("FAIL scoreboard got res=%h pp=%h en=%b expected res=%h pp=%h en=%b",
                         res_out, pp_out, pp_en, g.res, g.pp, g.en);
            end
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        p_sel = 1; p_ce = 1; p_we = 1; p_addr = a; p_wdata = d; p_strb = s;
        step();
        p_sel = 0; p_ce = 0; p_we = 0; p_strb = 0;
    endtask

    task automatic test_reset();
        rstn = 1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({res_out, pp_out, pp_en} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got res=%h pp=%h en=%b expected all 0", res_out, pp_out, pp_en);
        end
        n_checks++;
        if (p_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy got %b expected 0", p_rdy);
        end
        p_sel = 1; p_addr = 3;
        #1;
        n_checks++;
        if (p_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_readback got %h expected 0", p_rdata);
        end
        p_sel = 0;
        model_clear();
        rstn = 0;
    endtask

    task automatic test_bus();
        p_sel = 1; p_ce = 0; p_we = 1; p_addr = 3; p_wdata = 32'h12345678; p_strb = 4'b0011;
        #1;
        n_checks++;
        if (p_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_rdy_setup got %b expected 0", p_rdy);
        end
        p_ce = 1;
        #1;
        n_checks++;
        if (p_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_rdy_access got %b expected 1", p_rdy);
        end
        step();
        p_addr = 16; p_wdata = 32'hFFFFFFFF; p_strb = 4'hF;
        step();
        p_ce = 0; p_we = 0; p_addr = 3;
        #1;
        n_checks++;
        if (p_rdata !== 32'h00005678) begin
            n_fail++;
            $display("FAIL bus_read3 got %h expected 00005678", p_rdata);
        end
        p_addr = 16;
        #1;
        n_checks++;
        if (p_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL bus_read16 got %h expected 0", p_rdata);
        end
        p_addr = 0;
        #1;
        n_checks++;
        if (p_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL bus_read0_after_oob got %h expected 0", p_rdata);
        end
        p_addr = 3; p_we = 1;
        #1;
        n_checks++;
        if (p_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL bus_read_we got %h expected 0", p_rdata);
        end
        p_sel = 0; p_we = 0;
        bus_write(3, 32'd0, 4'hF);
    endtask

    task automatic test_impulse();
        bus_write(2, 32'h2000, 4'hF);
        en = 1; din = 16'h8000;
        repeat (D + L) step();
        din = 16'h8064;
        step();
        din = 16'h8000;
        for (int i = 1; i <= L + 6; i++) begin
            step();
            n_checks++;
            if (res_out !== ((i == L + 2) ? 16'h80C8 : 16'h8000)) begin
                n_fail++;
                $display("FAIL impulse_res step %0d got %h expected %h", i, res_out,
                         (i == L + 2) ? 16'h80C8 : 16'h8000);
            end
            if (i == L) begin
                n_checks++;
                if (pp_out !== 16'h8064) begin
                    n_fail++;
                    $display("FAIL impulse_pp got %h expected 8064", pp_out);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < D; k++) bus_write(k, 32'h1000, 4'hF);
        din = 16'hFFFF;
        repeat (D + L + 1) step();
        n_checks++;
        if (res_out !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_high got %h expected FFFF", res_out);
        end
        din = 16'h0000;
        repeat (D + L + 1) step();
        n_checks++;
        if (res_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL sat_low got %h expected 0000", res_out);
        end
    endtask

    task automatic test_gating();
        logic [15:0] hold = 0;
        for (int k = 0; k < D; k++) bus_write(k, {16'hABCD, 16'(k * 300 - 2000)}, 4'hF);
        for (int i = 0; i < 30; i++) begin
            en = !(i >= 10 && i < 14);
            din = 16'($urandom);
            step();
            if (i == 9 + L) hold = res_out;
            if (i >= 10 + L && i <= 13 + L) begin
                n_checks++;
                if (pp_en !== 1'b0 || res_out !== hold) begin
                    n_fail++;
                    $display("FAIL gating_gap step %0d got en=%b res=%h expected en=0 res=%h", i, pp_en, res_out, hold);
                end
            end
            if (i == 9 + L || i == 14 + L) begin
                n_checks++;
                if (pp_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gating_edge step %0d got en=%b expected 1", i, pp_en);
                end
            end
        end
        en = 1;
    endtask

    task automatic test_reset_midstream();
        bus_write(2, 32'h2000, 4'hF);
        din = 16'h8064;
        step();
        din = 16'h8000;
        repeat (3) step();
        rstn = 1;
        #1;
        n_checks++;
        if ({res_out, pp_out, pp_en} !== 33'd0) begin
            n_fail++;
            $display("FAIL midreset_immediate got res=%h pp=%h en=%b expected all 0", res_out, pp_out, pp_en);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({res_out, pp_out, pp_en} !== 33'd0) begin
            n_fail++;
            $display("FAIL midreset_held got res=%h pp=%h en=%b expected all 0", res_out, pp_out, pp_en);
        end
        model_clear();
        rstn = 0;
        p_sel = 1; p_addr = 2;
        #1;
        n_checks++;
        if (p_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_coef got %h expected 0", p_rdata);
        end
        p_sel = 0;
        for (int i = 0; i < L + 6; i++) begin
            step();
            if (i >= 1) begin
                n_checks++;
                if (res_out !== 16'h8000) begin
                    n_fail++;
                    $display("FAIL midreset_stale step %0d got %h expected 8000", i, res_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_impulse();
        test_saturation();
        test_gating();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/convolution_core.md
CONVOLUTION_CORE -- requirements
Module: convolution_core

Interface
REQ-001 Parameter CONV_CORE_DEPTH, default 16, SHALL set the number of FIR taps; it SHALL be a power of two, at least 2.
REQ-002 Parameter DATA_BITWIDTH, default 16, SHALL set the sample and coefficient width W.
REQ-003 Parameter OUTPUT_SHIFT_BITS, default 12, SHALL set the arithmetic right shift applied to the accumulated sum.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rstn  in  1  asynchronous, active-high reset (port name kept per codebase; high = reset).
REQ-006 data_in_enable  in  1  sample-valid strobe.
REQ-007 data_in  in  W  input sample, offset-binary (value minus 2^(W-1) is the signed sample).
REQ-008 data_pp_out_enable  out  1  data_in_enable delayed by latency L.
REQ-009 data_pp_out  out  W  data_in delayed by L, time-aligned with data_res_out.
REQ-010 data_res_out  out  W  filter result, offset-binary.
REQ-011 p_sel, p_ce, p_we  in  1 each  register-bus select, access-phase enable, write.
REQ-012 p_strb  in  4  byte-lane write strobes; p_addr  in  32  word index; p_wdata  in  32  write data.
REQ-013 p_rdy  out  1  transfer ready; p_rdata  out  32  read data.

Function
REQ-014 The block SHALL hold CONV_CORE_DEPTH 32-bit coefficient registers c[0..D-1]; c[k] bits W-1:0 form a signed W-bit tap, and upper bits are stored for readback only.
REQ-015 p_rdy SHALL equal p_sel AND p_ce (zero wait states).
REQ-016 On a rising edge with p_sel, p_ce, and p_we high and p_addr < D, c[p_addr] byte lane b SHALL be updated from p_wdata byte b when p_strb[b]=1.
REQ-017 p_rdata SHALL be c[p_addr] when p_sel=1, p_we=0, and p_addr < D, and 0 otherwise; writes with p_addr >= D SHALL be ignored.
REQ-018 A D-entry signed delay line x[0..D-1] SHALL shift by one only on cycles with data_in_enable=1, loading x[0] = data_in - 2^(W-1); with enable low it SHALL hold.
REQ-019 Result = sum over k of c[k]*x[k], using signed W x W products and an accumulator of 2W+log2(D) bits (no overflow possible).
REQ-020 The accumulator SHALL be arithmetic-shifted right by OUTPUT_SHIFT_BITS, saturated to signed W range [-2^(W-1), 2^(W-1)-1], then offset by +2^(W-1) (MSB inverted) to form data_res_out.
REQ-021 The pipeline SHALL have one product register stage, log2(D) adder-tree stages, and one output register stage, so latency L = log2(D)+2 cycles (6 at defaults) from the edge that loads x[0].
REQ-022 The multiply/add pipeline SHALL advance every cycle; an enable tag and the raw data_in SHALL travel alongside it to data_pp_out_enable and data_pp_out.
REQ-023 A coefficient write SHALL affect products computed on the following cycle; results already in flight SHALL not be corrected.
REQ-024 A simultaneous coefficient write and sample enable SHALL both take effect; neither SHALL be dropped.

Reset
REQ-025 While rstn=1, all coefficients, delay-line entries, pipeline registers, data_pp_out_enable, data_pp_out, and data_res_out SHALL be 0.
REQ-026 p_rdata and p_rdy SHALL remain combinational per REQ-015 and REQ-017.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight results immediately.
REQ-028 After reset with zero coefficients, data_res_out SHALL read 0x8000 (W=16) once the pipeline has advanced L cycles.

Structure
REQ-029 Package convolution_core_pkg SHALL hold the derived constants (TAP_ADDR_W = log2(D), ACC_W = 2W+log2(D), OFFSET = 2^(W-1)) and the saturate/offset helper function.
REQ-030 The pipelined adder tree SHALL be one sub-module, conv_adder_tree, parameterised by input count and width, with log2(N) register stages.

Verification
REQ-031 Reset: assert rstn for 5 cycles -> all outputs 0, p_rdy 0 while p_sel=0, coefficient readback 0.
REQ-032 Bus: write c[3]=0x12345678 with strobes 4'b0011, then read addr 3 -> p_rdata 0x00005678, p_rdy high in the first access-phase cycle; write to addr 16 is ignored.
REQ-033 Impulse: c[2]=0x2000, others 0, continuous enable, data_in 0x8064 for one sample then 0x8000 -> data_res_out 0x80C8 exactly L+2 cycles after the impulse, 0x8000 otherwise; data_pp_out shows 0x8064 L cycles after input.
REQ-034 Saturation: all c[k]=0x1000, data_in held 0xFFFF -> data_res_out 0xFFFF; data_in held 0x0000 -> 0x0000.
REQ-035 Gating: drop data_in_enable for 4 cycles mid-stream -> delay line frozen, data_pp_out_enable low for exactly those 4 cycles delayed by L, and data_res_out constant during the gap.
REQ-036 Reset mid-stream: assert rstn during an active impulse -> outputs 0 immediately and no stale result after release.
